ex_div_ctrl: RTL
================

Name: ex_div_ctrl

Overview:
- Multi-cycle RV32M divide/remainder sequencer placed alongside the EX-stage ALU.
- Accepts a DIV/DIVU/REM/REMU request from ID and runs a radix-2 restoring division, one quotient bit per cycle.
- Stalls IF/ID/EX while the operation runs, then presents the result for one cycle so it can be muxed onto the EX result path toward MEM.
- Supports pipeline flush and special-case early-out.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN; counter width is clog2(XLEN).

Ports:
clk  input  1  clock, rising-edge
rst  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  ID/EX holds a valid M-extension divide instruction (opcode 0110011, funct7 0000001, funct3[2]=1)
op  input  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
rs1_data  input  XLEN  dividend (already forwarded)
rs2_data  input  XLEN  divisor (already forwarded)
rd  input  5  destination register
flush  input  1  squash in-flight operation (branch/jump redirect)
stall  output  1  hold PC, IF/ID and ID/EX registers
done  output  1  result valid this cycle; one-cycle pulse
result  output  XLEN  quotient or remainder
result_rd  output  5  rd of the completed operation

Behaviour:
- Reset (rst=0, async): state=IDLE, counter=0, all internal registers=0; stall=0, done=0, result=0, result_rd=0.
- States:
  - IDLE: stall = start & ~flush (combinational). On a clock edge with start=1 and flush=0:
    - latch op, rd, sign flags, and magnitudes. For signed ops the magnitude is the two's-complement absolute value; for unsigned ops the operand is used raw.
    - divisor==0 -> DONE with quotient=all ones and remainder=rs1_data. This applies to all four ops.
    - DIV/REM with rs1=0x80000000, rs2=0xFFFFFFFF -> DONE with quotient=0x80000000 and remainder=0.
    - otherwise -> CALC with counter=XLEN-1, remainder register=0, quotient register=|dividend|.
  - CALC: stall=1. Each cycle:
    - shift {rem,quo} left by 1;
    - trial = rem_shifted - |divisor|, computed XLEN+1 bits wide;
    - if trial is non-negative, rem=trial and quo[0]=1; otherwise quo[0]=0.
    - When counter==0, go to DONE; otherwise decrement the counter.
  - DONE: stall=0, done=1. result selects by op:
    - DIV: quotient, negated if the dividend and divisor signs differ.
    - REM: remainder, negated if the dividend was negative.
    - DIVU/REMU: raw quotient/remainder.
    - Special-case values pass through unmodified.
    - result_rd = latched rd. Always returns to IDLE next cycle.
- start is ignored in DONE. The pipeline advances on the DONE cycle, so the same instruction is not reissued.
- result is registered and stays stable during DONE. Outside DONE it holds its last value; consumers must qualify it with done.
- Latency, with start sampled at edge T:
  - normal: stall high for the cycle before T, then CALC runs for XLEN cycles and DONE is at cycle T+XLEN+1. Total stall is XLEN+1 cycles.
  - special case: DONE at cycle T+1, one stall cycle.
- flush=1 in any state: go to IDLE at the next edge. done is forced to 0 in the flush cycle and no result is produced. stall=0 in the flush cycle.
- flush and start together in IDLE: flush wins and nothing is latched.
- Reset asserted mid-CALC: immediate return to IDLE with outputs at their reset values. No partial result is emitted after reset release.
- Back-to-back divides: a second start is accepted in the IDLE cycle immediately after DONE.

Test Plan:
- DIVU 100/7, start for 1 issue -> stall=1 for 33 cycles, then done=1 for one cycle with result=14, result_rd=latched rd; REMU same operands -> result=2.
- DIV -7/2 (0xFFFFFFF9, 2) -> result 0xFFFFFFFD (-3); REM -> 0xFFFFFFFF (-1); REM 7/-2 -> result 1.
- Divide by zero: DIV 5/0 -> done at T+1, result 0xFFFFFFFF; REMU 5/0 -> result 5; stall high exactly one cycle.
- Overflow: DIV 0x80000000/0xFFFFFFFF -> done at T+1 with result 0x80000000; REM same operands -> 0.
- flush asserted on CALC cycle 10 -> IDLE next edge, stall drops, done never pulses; a new DIVU 9/3 then yields 3 after a full 33-cycle stall.
- rst driven low asynchronously mid-CALC -> stall/done/result go to 0 without waiting for a clock edge; after release with start=0 the block stays in IDLE with done=0; back-to-back DIVU then REMU complete correctly with 33 stall cycles each.

Source files
------------

// File: rtl/ex_div_ctrl.sv
// RV32M divide/remainder sequencer beside the EX-stage ALU: radix-2 restoring
// division, one quotient bit per cycle, with divide-by-zero and overflow early-out.
module ex_div_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      result_rd
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [1:0]        op_q, op_d;
  logic [4:0]        rd_q, rd_d, result_rd_q, result_rd_d;
  logic              nega_q, nega_d, negb_q, negb_d;

  function automatic logic [XLEN-1:0] fix_result(input logic [1:0] o,
                                                  input logic [XLEN-1:0] q,
                                                  input logic [XLEN-1:0] r,
                                                  input logic na,
                                                  input logic nb);
    case (o)
      2'b00:   fix_result = (na ^ nb) ? -q : q;
      2'b01:   fix_result = q;
      2'b10:   fix_result = na ? -r : r;
      default: fix_result = r;
    endcase
  endfunction

  logic              is_signed, a_neg, b_neg, ovf;
  logic [XLEN-1:0]   a_mag, b_mag, quo_sh, rem_nx;
  logic [XLEN:0]     rem_sh, trial;

  assign is_signed = ~op[0];
  assign a_neg     = is_signed & rs1_data[XLEN-1];
  assign b_neg     = is_signed & rs2_data[XLEN-1];
  assign a_mag     = a_neg ? -rs1_data : rs1_data;
  assign b_mag     = b_neg ? -rs2_data : rs2_data;
  assign ovf       = is_signed & (rs1_data == INT_MIN) & (rs2_data == '1);

  // Remainder stays below the divisor, so the XLEN+1 bit trial sign is exact.
  assign rem_sh = {rem_q, quo_q[XLEN-1]};
  assign trial  = rem_sh - {1'b0, dvs_q};
  assign quo_sh = {quo_q[XLEN-2:0], ~trial[XLEN]};
  assign rem_nx = trial[XLEN] ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    op_d        = op_q;
    rd_d        = rd_q;
    nega_d      = nega_q;
    negb_d      = negb_q;
    result_d    = result_q;
    result_rd_d = result_rd_q;
    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          op_d   = op;
          rd_d   = rd;
          nega_d = a_neg;
          negb_d = b_neg;
          dvs_d  = b_mag;
          if (rs2_data == '0) begin
            state_d     = DONE;
            result_d    = op[1] ? rs1_data : '1;
            result_rd_d = rd;
          end else if (ovf) begin
            state_d     = DONE;
            result_d    = op[1] ? '0 : INT_MIN;
            result_rd_d = rd;
          end else begin
            state_d = CALC;
            cnt_d   = CNT_W'(XLEN - 1);
            rem_d   = '0;
            quo_d   = a_mag;
          end
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          rem_d = rem_nx;
          quo_d = quo_sh;
          if (cnt_q == '0) begin
            state_d     = DONE;
            result_d    = fix_result(op_q, quo_sh, rem_nx, nega_q, negb_q);
            result_rd_d = rd_q;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      op_q        <= '0;
      rd_q        <= '0;
      nega_q      <= 1'b0;
      negb_q      <= 1'b0;
      result_q    <= '0;
      result_rd_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      nega_q      <= nega_d;
      negb_q      <= negb_d;
      result_q    <= result_d;
      result_rd_q <= result_rd_d;
    end
  end

  // Stall releases in the flush cycle so the redirect can proceed immediately.
  always_comb begin
    stall = 1'b0;
    case (state_q)
      IDLE:    stall = rst & start & ~flush;
      CALC:    stall = rst & ~flush;
      default: stall = 1'b0;
    endcase
  end

  assign done      = rst & (state_q == DONE) & ~flush;
  assign result    = result_q;
  assign result_rd = result_rd_q;

endmodule
